// File: rtl/pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwr_seq_pkg
//  Purpose  : Shared types and helpers for the power-sequencing Avalon master.
//  Revision : 1.0  initial release
// ============================================================================
package pwr_seq_pkg;

    localparam int AVALON_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CHK  = 3'd3,
        ST_DLY  = 3'd4,
        ST_FIN  = 3'd5,
        ST_ERR  = 3'd6
    } seq_state_t;

    // Width of a step index able to address n_steps entries (minimum 1 bit).
    function automatic int step_idx_w(input int n_steps);
        return (n_steps <= 2) ? 1 : $clog2(n_steps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwr_seq_avm_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwr_seq_avm_if
//  Purpose  : Avalon-MM read/write bundle between the sequencer and the fabric.
//  Revision : 1.0  initial release
// ============================================================================
interface pwr_seq_avm_if
    import pwr_seq_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0]        avm_address;
    logic                     avm_write;
    logic [AVALON_DATA_W-1:0] avm_writedata;
    logic                     avm_read;
    logic [AVALON_DATA_W-1:0] avm_readdata;
    logic                     avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/pwr_seq_delay.sv
`default_nettype none
// ============================================================================
//  Module   : pwr_seq_delay
//  Purpose  : Loadable down-counter timing the post-step wait.
//  Revision : 1.0  initial release
// ============================================================================
module pwr_seq_delay #(
    parameter int DELAY_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_load,
    input  wire logic               i_dec,
    input  wire logic [DELAY_W-1:0] i_value,
    output logic                    o_zero
);

    logic [DELAY_W-1:0] r_count;

    // Saturates at zero so a stray decrement can never wrap into a long wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - DELAY_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pwr_seq_master.sv
`default_nettype none
// ============================================================================
//  Module   : pwr_seq_master
//  Purpose  : Avalon-MM initiator walking a fixed write/verify/delay table
//             to bring up board power and clock enables.
//  Revision : 1.0  initial release
// ============================================================================
module pwr_seq_master
    import pwr_seq_pkg::*;
#(
    parameter int                          N_STEPS     = 4,
    parameter int                          ADDR_W      = 8,
    parameter int                          DELAY_W     = 16,
    parameter logic [ADDR_W*N_STEPS-1:0]   STEP_ADDR   = {N_STEPS{8'h00}},
    parameter logic [32*N_STEPS-1:0]       STEP_DATA   = {N_STEPS{32'h1}},
    parameter logic [DELAY_W*N_STEPS-1:0]  STEP_DELAY  = {N_STEPS{16'd100}},
    parameter logic [31:0]                 VERIFY_MASK = 32'h0000_0001
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic        abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [3:0]       err_step,
    pwr_seq_avm_if.master    avm
);

    localparam int                 c_idx_w  = step_idx_w(N_STEPS);
    localparam logic [c_idx_w-1:0] c_last   = c_idx_w'(N_STEPS - 1);
    localparam logic               c_verify = (VERIFY_MASK != 32'h0);

    seq_state_t                 r_state,   w_state_nxt;
    logic [c_idx_w-1:0]         r_step,    w_step_nxt;
    logic                       r_busy,    w_busy_nxt;
    logic                       r_done,    w_done_nxt;
    logic                       r_error,   w_error_nxt;
    logic [3:0]                 r_err_step, w_err_step_nxt;
    logic                       r_abort_pend, w_abort_nxt;
    logic [AVALON_DATA_W-1:0]   r_rdata;

    logic                       w_load;
    logic                       w_dec;
    logic                       w_zero;
    logic                       w_wr;
    logic                       w_rd;
    logic                       w_capture;
    logic                       w_abort;
    logic [ADDR_W-1:0]          w_step_addr;
    logic [AVALON_DATA_W-1:0]   w_step_data;
    logic [DELAY_W-1:0]         w_step_delay;

    assign w_step_addr  = STEP_ADDR [int'(r_step)*ADDR_W  +: ADDR_W];
    assign w_step_data  = STEP_DATA [int'(r_step)*32      +: 32];
    assign w_step_delay = STEP_DELAY[int'(r_step)*DELAY_W +: DELAY_W];
    assign w_abort      = r_abort_pend | abort;

    pwr_seq_delay #(
        .DELAY_W (DELAY_W)
    ) u_delay (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_dec   (w_dec),
        .i_value (w_step_delay),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_err_step_nxt = r_err_step;
        w_abort_nxt    = r_abort_pend | abort;
        w_load         = 1'b0;
        w_dec          = 1'b0;
        w_wr           = 1'b0;
        w_rd           = 1'b0;
        w_capture      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A start in the same cycle as an abort wins; stale aborts are dropped here.
                w_abort_nxt = 1'b0;
                if (start) begin
                    w_done_nxt     = 1'b0;
                    w_error_nxt    = 1'b0;
                    w_err_step_nxt = 4'd0;
                    w_busy_nxt     = 1'b1;
                    w_step_nxt     = '0;
                    w_state_nxt    = ST_WR;
                end
            end
            ST_WR: begin
                w_wr = 1'b1;
                if (!avm.avm_waitrequest) begin
                    if (w_abort) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b0;
                        w_abort_nxt = 1'b0;
                    end else if (c_verify) begin
                        w_state_nxt = ST_RD;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_DLY;
                    end
                end
            end
            ST_RD: begin
                w_rd = 1'b1;
                if (!avm.avm_waitrequest) begin
                    w_capture = 1'b1;
                    if (w_abort) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b0;
                        w_abort_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_abort_nxt = 1'b0;
                end else if (((r_rdata ^ w_step_data) & VERIFY_MASK) != 32'h0) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_DLY;
                end
            end
            ST_DLY: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_abort_nxt = 1'b0;
                end else if (w_zero) begin
                    if (r_step == c_last) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_step_nxt  = r_step + c_idx_w'(1);
                        w_state_nxt = ST_WR;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_abort_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_error_nxt    = 1'b1;
                w_err_step_nxt = 4'(r_step);
                w_busy_nxt     = 1'b0;
                w_abort_nxt    = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_abort_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_step   <= 4'd0;
            r_abort_pend <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_err_step   <= w_err_step_nxt;
            r_abort_pend <= w_abort_nxt;
            if (w_capture) begin
                r_rdata <= avm.avm_readdata;
            end
        end
    end

    // Bus outputs decode straight from registered state, so they stay frozen through a stall.
    assign avm.avm_write     = w_wr;
    assign avm.avm_read      = w_rd;
    assign avm.avm_address   = (w_wr || w_rd) ? w_step_addr : '0;
    assign avm.avm_writedata = w_wr ? w_step_data : '0;

    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_step = r_err_step;

endmodule
`default_nettype wire

// File: tb/tb_pwr_seq_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwr_seq_master
//  Purpose  : Scoreboarded bench for pwr_seq_master with an echoing PIO slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwr_seq_master;

    localparam int N = 3;
    localparam logic [7:0]  c_addr  [N] = '{8'h00, 8'h04, 8'h08};
    localparam logic [31:0] c_data  [N] = '{32'h1, 32'h3, 32'h5};
    localparam int          c_delay [N] = '{3, 5, 2};

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, error;
    logic [3:0]  err_step;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    wr_t         exp_q[$];
    logic [7:0]  last_wr_addr = 8'h00;
    int          wr_acc = 0, rd_acc = 0, wr_stall = 0, rd_stall = 0;

    // slave configuration (written only by the stimulus process)
    logic [7:0]  ws_addr = 8'h00;
    int          ws_wr_n = 0;
    int          ws_rd_n = 0;
    logic        zero_en = 1'b0;
    logic [7:0]  zero_addr = 8'h00;

    logic [31:0] mem [0:255];
    int          wr_cnt = 0, rd_cnt = 0;

    pwr_seq_avm_if #(.ADDR_W(8)) avm_if ();

    pwr_seq_master #(
        .N_STEPS     (N),
        .ADDR_W      (8),
        .DELAY_W     (16),
        .STEP_ADDR   ({8'h08, 8'h04, 8'h00}),
        .STEP_DATA   ({32'h5, 32'h3, 32'h1}),
        .STEP_DELAY  ({16'd2, 16'd5, 16'd3}),
        .VERIFY_MASK (32'h0000_0001)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_step (err_step),
        .avm      (avm_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Echoing slave with per-address stall injection and optional zero readback.
    assign avm_if.avm_waitrequest =
        (avm_if.avm_write && avm_if.avm_address == ws_addr && wr_cnt < ws_wr_n) ||
        (avm_if.avm_read  && avm_if.avm_address == ws_addr && rd_cnt < ws_rd_n);
    assign avm_if.avm_readdata =
        (zero_en && avm_if.avm_address == zero_addr) ? 32'h0 : mem[avm_if.avm_address];

    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (avm_if.avm_write && !avm_if.avm_waitrequest)
            mem[avm_if.avm_address] <= avm_if.avm_writedata;
        wr_cnt <= (avm_if.avm_write && avm_if.avm_waitrequest) ? wr_cnt + 1 : 0;
        rd_cnt <= (avm_if.avm_read  && avm_if.avm_waitrequest) ? rd_cnt + 1 : 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Bus monitor: pops the scoreboard on every accepted write.
    always @(negedge clk) begin
        if (!reset) begin
            check_eq("rw_exclusive", {31'h0, avm_if.avm_write & avm_if.avm_read}, 32'h0);
            if (avm_if.avm_write) begin
                check_eq("wr_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0) begin
                    check_eq("wr_addr", {24'h0, avm_if.avm_address}, {24'h0, exp_q[0].addr});
                    check_eq("wr_data", avm_if.avm_writedata, exp_q[0].data);
                    if (!avm_if.avm_waitrequest) begin
                        last_wr_addr = exp_q[0].addr;
                        void'(exp_q.pop_front());
                        wr_acc++;
                    end else begin
                        wr_stall++;
                    end
                end
            end
            if (avm_if.avm_read) begin
                check_eq("rd_addr", {24'h0, avm_if.avm_address}, {24'h0, last_wr_addr});
                if (!avm_if.avm_waitrequest) rd_acc++;
                else rd_stall++;
            end
        end
    end

    function automatic int exp_lat(input int n_steps);
        int s = 1;
        for (int i = 0; i < n_steps; i++) s += c_delay[i] + 4;
        return s;
    endfunction

    task automatic push_steps(input int n_steps);
        for (int i = 0; i < n_steps; i++) exp_q.push_back('{c_addr[i], c_data[i]});
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idle(input int t0, output int lat);
        for (int n = 0; n < 300 && busy; n++) @(negedge clk);
        if (busy) check_eq("busy_timeout", {31'h0, busy}, 32'h0);
        lat = cyc - t0;
    endtask

    task automatic clear_cfg();
        ws_addr = 8'h00; ws_wr_n = 0; ws_rd_n = 0; zero_en = 1'b0;
    endtask

    initial begin
        int t0, lat, a0, a1, s0, r0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy",  {31'h0, busy},  32'h0);
        check_eq("rst_done",  {31'h0, done},  32'h0);
        check_eq("rst_error", {31'h0, error}, 32'h0);
        check_eq("rst_errstep", {28'h0, err_step}, 32'h0);
        check_eq("rst_wr", {31'h0, avm_if.avm_write}, 32'h0);
        check_eq("rst_rd", {31'h0, avm_if.avm_read}, 32'h0);
        check_eq("rst_addr", {24'h0, avm_if.avm_address}, 32'h0);
        reset = 1'b0;

        // 1: clean sequence, no waitstates
        clear_cfg();
        push_steps(N);
        a0 = wr_acc; r0 = rd_acc;
        pulse_start(t0);
        check_eq("t1_busy_rise", {31'h0, busy}, 32'h1);
        wait_idle(t0, lat);
        check_eq("t1_latency", lat, exp_lat(N));
        check_eq("t1_done", {31'h0, done}, 32'h1);
        check_eq("t1_error", {31'h0, error}, 32'h0);
        check_eq("t1_writes", wr_acc - a0, N);
        check_eq("t1_reads", rd_acc - r0, N);
        check_eq("t1_q_empty", exp_q.size(), 0);

        // 2: five-cycle stall on the step-0 write
        clear_cfg(); ws_addr = c_addr[0]; ws_wr_n = 5;
        push_steps(N);
        a0 = wr_acc; s0 = wr_stall;
        pulse_start(t0);
        wait_idle(t0, lat);
        check_eq("t2_stalls", wr_stall - s0, 5);
        check_eq("t2_writes", wr_acc - a0, N);
        check_eq("t2_latency", lat, exp_lat(N) + 5);
        check_eq("t2_done", {31'h0, done}, 32'h1);
        check_eq("t2_q_empty", exp_q.size(), 0);

        // 3: step-1 readback returns zero
        clear_cfg(); zero_en = 1'b1; zero_addr = c_addr[1];
        push_steps(2);
        pulse_start(t0);
        wait_idle(t0, lat);
        check_eq("t3_latency", lat, (c_delay[0] + 4) + 3 + 1);
        check_eq("t3_error", {31'h0, error}, 32'h1);
        check_eq("t3_err_step", {28'h0, err_step}, 32'h1);
        check_eq("t3_done", {31'h0, done}, 32'h0);
        repeat (6) @(negedge clk);
        check_eq("t3_q_empty", exp_q.size(), 0);
        zero_en = 1'b0;

        // 4: abort during a stalled step-0 read
        clear_cfg(); ws_addr = c_addr[0]; ws_rd_n = 6;
        push_steps(1);
        a0 = wr_acc; r0 = rd_acc; s0 = rd_stall;
        pulse_start(t0);
        for (int n = 0; n < 20 && !(avm_if.avm_read && avm_if.avm_waitrequest); n++) @(negedge clk);
        check_eq("t4_stalled_rd", {31'h0, avm_if.avm_read & avm_if.avm_waitrequest}, 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle(t0, lat);
        check_eq("t4_rd_stalls", rd_stall - s0, 6);
        check_eq("t4_reads", rd_acc - r0, 1);
        check_eq("t4_writes", wr_acc - a0, 1);
        check_eq("t4_busy", {31'h0, busy}, 32'h0);
        check_eq("t4_done", {31'h0, done}, 32'h0);
        check_eq("t4_error", {31'h0, error}, 32'h0);
        repeat (5) @(negedge clk);
        check_eq("t4_q_empty", exp_q.size(), 0);

        // 5: reset during step-1 delay, then rerun from step 0
        clear_cfg();
        push_steps(2);
        pulse_start(t0);
        repeat (11) @(negedge clk);
        check_eq("t5_pre_rst_q", exp_q.size(), 0);
        check_eq("t5_pre_rst_busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_busy", {31'h0, busy}, 32'h0);
        check_eq("t5_done", {31'h0, done}, 32'h0);
        check_eq("t5_error", {31'h0, error}, 32'h0);
        check_eq("t5_wr", {31'h0, avm_if.avm_write}, 32'h0);
        check_eq("t5_rd", {31'h0, avm_if.avm_read}, 32'h0);
        reset = 1'b0;
        push_steps(N);
        pulse_start(t0);
        wait_idle(t0, lat);
        check_eq("t5_rerun_latency", lat, exp_lat(N));
        check_eq("t5_rerun_done", {31'h0, done}, 32'h1);
        check_eq("t5_q_empty", exp_q.size(), 0);

        // 6a: second start while busy is ignored
        push_steps(N);
        pulse_start(t0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(t0, lat);
        check_eq("t6a_latency", lat, exp_lat(N));
        check_eq("t6a_done", {31'h0, done}, 32'h1);
        repeat (5) @(negedge clk);
        check_eq("t6a_busy", {31'h0, busy}, 32'h0);
        check_eq("t6a_q_empty", exp_q.size(), 0);

        // 6b: start and abort together in idle
        push_steps(N);
        a0 = wr_acc;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        t0 = cyc;
        wait_idle(t0, lat);
        check_eq("t6b_latency", lat, exp_lat(N));
        check_eq("t6b_done", {31'h0, done}, 32'h1);
        check_eq("t6b_error", {31'h0, error}, 32'h0);
        check_eq("t6b_writes", wr_acc - a0, N);
        a1 = exp_q.size();
        check_eq("t6b_q_empty", a1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
